// File: rtl/data_memory_ctrl.sv
// Data RAM for the CPU load/store path: registered read port, zeroing sweep
// after reset and on request, out-of-range detection, and a ready handshake.
module data_memory_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   ram [DEPTH];

  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic                accepted;
  logic                conflict;
  logic                ram_we;
  logic [IDX_W-1:0]    ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rd;

  // Address decode: no wrap, anything at or beyond DEPTH is rejected.
  always_comb begin
    in_range = ({1'b0, addr} < DEPTH_A);
    idx      = addr[IDX_W-1:0];
    accepted = (state_q == ST_IDLE) && !clear_req && (mem_read || mem_write);
    conflict = mem_read && mem_write;
    ram_rd   = ram[idx];
  end

  // State register; reset restarts the zeroing sweep from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: sweep ends after the last word; clear_req restarts it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (clr_ptr_q == LAST_IDX) state_d = ST_IDLE;
      ST_IDLE:  if (clear_req)             state_d = ST_CLEAR;
      default:                             state_d = ST_CLEAR;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    ready = (state_q == ST_IDLE);
  end

  // Datapath next values: sweep pointer, RAM write port, read/err results.
  always_comb begin
    clr_ptr_d = '0;
    ram_we    = 1'b0;
    ram_waddr = idx;
    ram_wdata = wdata;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    if (state_q == ST_CLEAR) begin
      // Pointer parks at 0 when leaving CLEAR so a later sweep starts clean.
      if (clr_ptr_q != LAST_IDX) clr_ptr_d = clr_ptr_q + IDX_W'(1);
      ram_we    = 1'b1;
      ram_waddr = clr_ptr_q;
      ram_wdata = '0;
    end else if (accepted) begin
      if (conflict || !in_range) err_d = 1'b1;
      if (mem_write && !mem_read && in_range) ram_we = 1'b1;
      if (mem_read && !mem_write) begin
        rvalid_d = 1'b1;
        rdata_d  = in_range ? ram_rd : '0;
      end
    end
  end

  // Control and read-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_ptr_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clr_ptr_q <= clr_ptr_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  // Storage array: single write port shared by the sweep and stores.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule
